// File: rtl/wb_arbiter.sv
// Round-robin Wishbone classic arbiter: instruction and data masters share one slave.
// The grant is locked for the winner's whole cyc, and a watchdog aborts stalled strobes with err.
//
// state | meaning
// IDLE  | no master granted; slave bus held at zero
// GNT_I | instruction master owns the slave
// GNT_D | data master owns the slave
// ERR   | one-cycle err pulse to the master that timed out
module wb_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [XLEN-1:0]   i_adr,
  input  logic [XLEN-1:0]   i_dat_w,
  input  logic [XLEN/8-1:0] i_sel,
  output logic [XLEN-1:0]   i_dat_r,
  output logic              i_ack,
  output logic              i_err,

  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_adr,
  input  logic [XLEN-1:0]   d_dat_w,
  input  logic [XLEN/8-1:0] d_sel,
  output logic [XLEN-1:0]   d_dat_r,
  output logic              d_ack,
  output logic              d_err,

  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [XLEN-1:0]   s_adr,
  output logic [XLEN-1:0]   s_dat_w,
  output logic [XLEN/8-1:0] s_sel,
  input  logic [XLEN-1:0]   s_dat_r,
  input  logic              s_ack
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ERR} state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        last_d;
  logic [15:0] wd_cnt;

  logic arb_now;
  logic pick_i;
  logic pick_d;
  logic wd_expire;

  always_comb begin
    arb_now   = (state == IDLE) ||
                ((state == GNT_I) && !i_cyc) ||
                ((state == GNT_D) && !d_cyc);
    // On a tie the master that was not granted last wins.
    pick_d    = d_cyc && (!i_cyc || !last_d);
    pick_i    = i_cyc && (!d_cyc || last_d);
    wd_expire = (wd_cnt == WD_LAST) && !s_ack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
      wd_cnt <= '0;
    end else if (arb_now) begin
      wd_cnt <= '0;
      if (pick_d) begin
        state  <= GNT_D;
        last_d <= 1'b1;
      end else if (pick_i) begin
        state  <= GNT_I;
        last_d <= 1'b0;
      end else begin
        state  <= IDLE;
      end
    end else begin
      case (state)
        GNT_I, GNT_D: begin
          if (wd_expire) begin
            state  <= ERR;
            wd_cnt <= '0;
          end else if (s_ack) begin
            wd_cnt <= '0;
          end else if (s_stb) begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          wd_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    case (state)
      GNT_I: begin
        s_cyc   = i_cyc;
        s_stb   = i_stb;
        s_we    = i_we;
        s_adr   = i_adr;
        s_dat_w = i_dat_w;
        s_sel   = i_sel;
      end
      GNT_D: begin
        s_cyc   = d_cyc;
        s_stb   = d_stb;
        s_we    = d_we;
        s_adr   = d_adr;
        s_dat_w = d_dat_w;
        s_sel   = d_sel;
      end
      default: ;
    endcase
  end

  // last_d still names the owner while in ERR, so it selects who gets the err pulse.
  always_comb begin
    i_ack   = s_ack && (state == GNT_I);
    d_ack   = s_ack && (state == GNT_D);
    i_err   = (state == ERR) && !last_d;
    d_err   = (state == ERR) && last_d;
    i_dat_r = s_dat_r;
    d_dat_r = s_dat_r;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (TIMEOUT = 8): grant order, lock, handoff, watchdog, reset.
module tb_wb_arbiter;
  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_cyc, i_stb, i_we;
  logic [XLEN-1:0]   i_adr, i_dat_w, i_dat_r;
  logic [XLEN/8-1:0] i_sel;
  logic              i_ack, i_err;
  logic              d_cyc, d_stb, d_we;
  logic [XLEN-1:0]   d_adr, d_dat_w, d_dat_r;
  logic [XLEN/8-1:0] d_sel;
  logic              d_ack, d_err;
  logic              s_cyc, s_stb, s_we;
  logic [XLEN-1:0]   s_adr, s_dat_w, s_dat_r;
  logic [XLEN/8-1:0] s_sel;
  logic              s_ack;

  int n_tests = 0;
  int n_fail  = 0;

  wb_arbiter #(.XLEN(XLEN), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_dat_w(i_dat_w),
    .i_sel(i_sel), .i_dat_r(i_dat_r), .i_ack(i_ack), .i_err(i_err),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_dat_w(d_dat_w),
    .d_sel(d_sel), .d_dat_r(d_dat_r), .d_ack(d_ack), .d_err(d_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_sel(s_sel), .s_dat_r(s_dat_r), .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_cyc = 0; i_stb = 0; i_we = 0; i_adr = '0; i_dat_w = '0; i_sel = '0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_adr = '0; d_dat_w = '0; d_sel = '0;
    s_ack = 0; s_dat_r = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    smp();
    chk("rst s_cyc", 32'(s_cyc), 32'd0);
    chk("rst s_stb", 32'(s_stb), 32'd0);
    chk("rst s_we",  32'(s_we),  32'd0);
    chk("rst s_sel", 32'(s_sel), 32'd0);
    chk("rst s_adr", s_adr, 32'd0);
    chk("rst s_dat_w", s_dat_w, 32'd0);
    chk("rst acks", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst errs", {30'd0, i_err, d_err}, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // Solo instruction fetch
    tick();
    i_cyc = 1; i_stb = 1; i_adr = 32'h100; i_sel = 4'hF;
    smp(); chk("solo c1 s_cyc", 32'(s_cyc), 32'd0);
    tick();
    smp();
    chk("solo c2 s_adr", s_adr, 32'h100);
    chk("solo c2 s_stb", 32'(s_stb), 32'd1);
    chk("solo c2 i_ack", 32'(i_ack), 32'd0);
    tick();
    s_ack = 1; s_dat_r = 32'h13;
    smp();
    chk("solo c3 s_adr", s_adr, 32'h100);
    chk("solo c3 i_ack", 32'(i_ack), 32'd1);
    chk("solo c3 i_dat_r", i_dat_r, 32'h13);
    chk("solo c3 d_ack", 32'(d_ack), 32'd0);
    tick();
    i_cyc = 0; i_stb = 0; s_ack = 0;
    smp(); chk("solo c4 s_cyc", 32'(s_cyc), 32'd0);

    // Simultaneous requests out of reset go to D, then handoff to I
    do_reset();
    tick();
    i_cyc = 1; i_stb = 1; i_adr = 32'h200;
    d_cyc = 1; d_stb = 1; d_adr = 32'h300;
    tick();
    s_ack = 1;
    smp();
    chk("tie1 s_adr", s_adr, 32'h300);
    chk("tie1 d_ack", 32'(d_ack), 32'd1);
    chk("tie1 i_ack", 32'(i_ack), 32'd0);
    tick();
    d_cyc = 0; d_stb = 0; s_ack = 0;
    tick();
    smp();
    chk("handoff s_cyc", 32'(s_cyc), 32'd1);
    chk("handoff s_adr", s_adr, 32'h200);
    tick();
    i_cyc = 0; i_stb = 0;
    tick();
    i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
    tick();
    smp();
    chk("tie2 s_adr", s_adr, 32'h300);
    tick();
    clear_inputs();
    tick();

    // Lock: I bursts 4 strobes while D waits
    tick();
    i_cyc = 1; i_stb = 1; i_adr = 32'h400;
    d_adr = 32'h500;
    for (int k = 0; k < 4; k++) begin
      tick();
      d_cyc = 1; d_stb = 1;
      i_adr = 32'h400 + 32'(4 * k);
      s_ack = 1;
      smp();
      chk($sformatf("lock%0d s_adr", k), s_adr, 32'h400 + 32'(4 * k));
      chk($sformatf("lock%0d i_ack", k), 32'(i_ack), 32'd1);
      chk($sformatf("lock%0d d_ack", k), 32'(d_ack), 32'd0);
    end
    tick();
    i_cyc = 0; i_stb = 0; s_ack = 0;
    smp();
    chk("lock drop s_cyc", 32'(s_cyc), 32'd0);
    chk("lock drop d_ack", 32'(d_ack), 32'd0);
    tick();
    smp();
    chk("lock d gnt s_adr", s_adr, 32'h500);
    chk("lock d gnt s_cyc", 32'(s_cyc), 32'd1);
    tick();
    clear_inputs();
    tick();

    // Timeout: D never acked, I pending
    do_reset();
    tick();
    d_cyc = 1; d_stb = 1; d_adr = 32'hDEAD0000;
    i_cyc = 1; i_stb = 1; i_adr = 32'h600;
    for (int k = 0; k < 8; k++) begin
      tick();
      smp();
      chk($sformatf("to N+%0d s_adr", k), s_adr, 32'hDEAD0000);
      chk($sformatf("to N+%0d d_err", k), 32'(d_err), 32'd0);
    end
    tick();
    smp();
    chk("to err d_err", 32'(d_err), 32'd1);
    chk("to err i_err", 32'(i_err), 32'd0);
    chk("to err s_cyc", 32'(s_cyc), 32'd0);
    tick();
    d_cyc = 0; d_stb = 0;
    smp();
    chk("to idle d_err", 32'(d_err), 32'd0);
    chk("to idle s_cyc", 32'(s_cyc), 32'd0);
    tick();
    smp();
    chk("to i gnt s_adr", s_adr, 32'h600);
    chk("to i gnt s_cyc", 32'(s_cyc), 32'd1);
    tick();
    clear_inputs();
    tick();

    // Ack arrives on the deadline cycle
    tick();
    d_cyc = 1; d_stb = 1; d_adr = 32'h700;
    for (int k = 0; k < 7; k++) begin
      tick();
      smp();
      chk($sformatf("dl N+%0d d_ack", k), 32'(d_ack), 32'd0);
    end
    tick();
    s_ack = 1;
    smp();
    chk("dl ack d_ack", 32'(d_ack), 32'd1);
    chk("dl ack d_err", 32'(d_err), 32'd0);
    tick();
    d_cyc = 0; d_stb = 0; s_ack = 0;
    smp(); chk("dl after d_err", 32'(d_err), 32'd0);
    tick();
    smp();
    chk("dl after2 d_err", 32'(d_err), 32'd0);
    chk("dl after2 s_cyc", 32'(s_cyc), 32'd0);

    // Reset in the middle of a D write
    tick();
    d_cyc = 1; d_stb = 1; d_we = 1; d_sel = 4'hF; d_adr = 32'h800; d_dat_w = 32'hCAFEBABE;
    tick();
    rst = 1;
    smp();
    chk("wr s_we", 32'(s_we), 32'd1);
    chk("wr s_dat_w", s_dat_w, 32'hCAFEBABE);
    chk("wr s_sel", 32'(s_sel), 32'hF);
    tick();
    rst = 0; d_cyc = 0; d_stb = 0; s_ack = 1;
    smp();
    chk("mrst s_cyc", 32'(s_cyc), 32'd0);
    chk("mrst s_we", 32'(s_we), 32'd0);
    chk("mrst s_sel", 32'(s_sel), 32'd0);
    chk("mrst d_ack", 32'(d_ack), 32'd0);
    tick();
    s_ack = 0;
    i_cyc = 1; i_stb = 1; i_adr = 32'h900;
    d_cyc = 1; d_stb = 1; d_adr = 32'hA00;
    tick();
    smp();
    chk("mrst tie s_adr", s_adr, 32'hA00);
    tick();
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
